// File: rtl/edh_dram_rd_if.sv
// AXI4 read-channel bundle between the EDH picture fetcher (master) and the DRAM slave.
interface edh_dram_rd_if #(
    parameter int ID_WIDTH   = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 128
);
    logic [ID_WIDTH-1:0]   arid_m_inf;
    logic [ADDR_WIDTH-1:0] araddr_m_inf;
    logic [7:0]            arlen_m_inf;
    logic [2:0]            arsize_m_inf;
    logic [1:0]            arburst_m_inf;
    logic                  arvalid_m_inf;
    logic                  arready_m_inf;
    logic [ID_WIDTH-1:0]   rid_m_inf;
    logic [DATA_WIDTH-1:0] rdata_m_inf;
    logic [1:0]            rresp_m_inf;
    logic                  rlast_m_inf;
    logic                  rvalid_m_inf;
    logic                  rready_m_inf;

    modport master (
        output arid_m_inf, araddr_m_inf, arlen_m_inf, arsize_m_inf, arburst_m_inf,
        output arvalid_m_inf, rready_m_inf,
        input  arready_m_inf, rid_m_inf, rdata_m_inf, rresp_m_inf, rlast_m_inf, rvalid_m_inf
    );

    modport slave (
        input  arid_m_inf, araddr_m_inf, arlen_m_inf, arsize_m_inf, arburst_m_inf,
        input  arvalid_m_inf, rready_m_inf,
        output arready_m_inf, rid_m_inf, rdata_m_inf, rresp_m_inf, rlast_m_inf, rvalid_m_inf
    );
endinterface

// File: rtl/edh_dram_rd.sv
// Fetches one 4 KB picture as a 256-beat AXI4 INCR burst and streams it through a 2-entry FIFO.
// Optional rlast framing check: define EDH_RD_LAST_CHECK_EN.
module edh_dram_rd #(
    parameter int                    ID_WIDTH   = 4,
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 128,
    parameter logic [ADDR_WIDTH-1:0] PIC_BASE   = 32'h0004_0000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    input  logic [3:0]            req_pic_no,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    input  logic                  out_ready,
    edh_dram_rd_if.master         axi
);
    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_DRAIN} state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic                  w_accept;
    logic                  w_push;
    logic                  w_pop;
    logic [ADDR_WIDTH-1:0] r_araddr;
    logic [7:0]            r_rx_cnt;
    logic [7:0]            r_tx_cnt;
    logic                  r_done;
    logic [DATA_WIDTH-1:0] r_mem [2];
    logic                  r_wptr;
    logic                  r_rptr;
    logic [1:0]            r_count;

    assign axi.arid_m_inf    = '0;
    assign axi.arlen_m_inf   = 8'd255;
    assign axi.arsize_m_inf  = 3'b100;
    assign axi.arburst_m_inf = 2'b01;
    assign axi.araddr_m_inf  = r_araddr;
    assign axi.arvalid_m_inf = (r_state == S_ADDR);
    // Backpressure comes only from the registered FIFO occupancy, never from out_ready.
    assign axi.rready_m_inf  = (r_state == S_DATA) && (r_count != 2'd2);

    assign w_push    = axi.rvalid_m_inf && axi.rready_m_inf;
    assign out_valid = (r_count != 2'd0);
    assign w_pop     = out_valid && out_ready;
    assign out_data  = r_mem[r_rptr];
    assign out_last  = (r_tx_cnt == 8'hFF) && out_valid;
    assign busy      = (r_state != S_IDLE);
    assign done      = r_done;

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (req_valid) begin
                    w_accept     = 1'b1;
                    w_state_next = S_ADDR;
                end
            end
            S_ADDR:  if (axi.arready_m_inf) w_state_next = S_DATA;
            S_DATA:  if (w_push && (r_rx_cnt == 8'hFF)) w_state_next = S_DRAIN;
            S_DRAIN: if (w_pop && out_last) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_araddr <= '0;
            r_rx_cnt <= '0;
            r_tx_cnt <= '0;
            r_done   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_done  <= (r_state == S_DRAIN) && w_pop && out_last;
            if (w_accept) begin
                r_araddr <= PIC_BASE + ADDR_WIDTH'({req_pic_no, 12'h000});
                r_rx_cnt <= '0;
                r_tx_cnt <= '0;
            end else begin
                if (w_push) r_rx_cnt <= r_rx_cnt + 8'd1;
                if (w_pop)  r_tx_cnt <= r_tx_cnt + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) r_mem[i] <= '0;
            r_wptr  <= 1'b0;
            r_rptr  <= 1'b0;
            r_count <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= axi.rdata_m_inf;
                r_wptr        <= ~r_wptr;
            end
            if (w_pop) r_rptr <= ~r_rptr;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

`ifdef EDH_RD_LAST_CHECK_EN
    logic r_err;
    wire  w_unused = &{1'b0, axi.rid_m_inf, axi.rresp_m_inf};

    // rlast must coincide exactly with the 256th beat; anything else is a framing error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_err <= 1'b0;
        else if (w_accept)
            r_err <= 1'b0;
        else if (w_push && (axi.rlast_m_inf != (r_rx_cnt == 8'hFF)))
            r_err <= 1'b1;
    end
    assign err = r_err;
`else
    wire w_unused = &{1'b0, axi.rid_m_inf, axi.rresp_m_inf, axi.rlast_m_inf};
    assign err = 1'b0;
`endif
endmodule

// File: tb/tb_edh_dram_rd.sv
// Directed bench for edh_dram_rd: behavioural AXI read slave plus stream sink, driven cycle by cycle.
`timescale 1ns/1ps
module tb_edh_dram_rd;
    localparam int IDW = 4;
    localparam int AW  = 32;
    localparam int DW  = 128;
`ifdef EDH_RD_LAST_CHECK_EN
    localparam logic LAST_CHK = 1'b1;
`else
    localparam logic LAST_CHK = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic [3:0]    req_pic_no = 4'd0;
    logic          busy, done, err, out_valid, out_last;
    logic [DW-1:0] out_data;
    logic          out_ready = 1'b0;

    edh_dram_rd_if #(.ID_WIDTH(IDW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) axi();

    edh_dram_rd #(.ID_WIDTH(IDW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .PIC_BASE(32'h0004_0000)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_pic_no(req_pic_no),
        .busy(busy), .done(done), .err(err), .out_valid(out_valid), .out_data(out_data),
        .out_last(out_last), .out_ready(out_ready), .axi(axi)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc = 0;
    int ar_delay = 0, ar_wait = 0, ar_hs_cnt = 0, ar_unstable = 0;
    logic ar_pend = 1'b0;
    logic [31:0] ar_prev_addr = '0;
    logic sl_active = 1'b0;
    int sl_beat = 0, bad_beat = -1;
    logic [31:0] sl_addr = '0;
    int rready_early = 0, rready_low_cnt = 0;
    int ready_mode = 0;
    logic [31:0] exp_addr = '0;
    int tx_exp = 0, beats_out = 0, first_push_cyc = 0, last_pop_cyc = -10;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [127:0] mk_beat(input logic [31:0] a, input int b);
        return {a, 88'h0, b[7:0]};
    endfunction

    // One clock: sample DUT at the falling edge, then drive slave and sink for the next rising edge.
    task automatic tick();
        @(negedge clk);
        cyc++;
        if (!rst_n) begin
            sl_active = 1'b0; ar_wait = 0; ar_pend = 1'b0;
            axi.arready_m_inf = 1'b0; axi.rvalid_m_inf = 1'b0; axi.rlast_m_inf = 1'b0;
            out_ready = 1'b0;
        end else begin
            if (axi.rready_m_inf && !sl_active) rready_early++;
            if (sl_active) begin
                axi.rvalid_m_inf = 1'b1;
                axi.rdata_m_inf  = mk_beat(sl_addr, sl_beat);
                axi.rlast_m_inf  = (sl_beat == 255) != (sl_beat == bad_beat);
                if (!axi.rready_m_inf) rready_low_cnt++;
                else begin
                    if (sl_beat == 0) first_push_cyc = cyc;
                    if (sl_beat == 255) sl_active = 1'b0;
                    sl_beat++;
                end
            end else begin
                axi.rvalid_m_inf = 1'b0;
                axi.rlast_m_inf  = 1'b0;
            end
            if (axi.arvalid_m_inf) begin
                if (ar_pend && axi.araddr_m_inf != ar_prev_addr) ar_unstable++;
                ar_pend = 1'b1;
                ar_prev_addr = axi.araddr_m_inf;
                if (ar_wait < ar_delay) begin
                    axi.arready_m_inf = 1'b0;
                    ar_wait++;
                end else begin
                    axi.arready_m_inf = 1'b1;
                    ar_hs_cnt++;
                    sl_addr = axi.araddr_m_inf;
                    sl_active = 1'b1; sl_beat = 0; ar_wait = 0; ar_pend = 1'b0;
                end
            end else begin
                if (ar_pend) ar_unstable++;
                axi.arready_m_inf = 1'b0;
                ar_wait = 0;
            end
            out_ready = (ready_mode == 0) ? 1'b1 : (cyc % 2 == 1);
            if (out_valid && out_ready) begin
                check("beat_data", out_data, mk_beat(exp_addr, tx_exp));
                check("beat_last", out_last, tx_exp == 255);
                if (tx_exp == 255) last_pop_cyc = cyc;
                tx_exp++;
                beats_out++;
            end
            if (done && cyc != last_pop_cyc + 1) check("done_spurious", done, 1'b0);
        end
    endtask

    task automatic expect_start(input logic [3:0] pic);
        exp_addr  = 32'h0004_0000 + {16'h0, pic, 12'h000};
        tx_exp    = 0;
        beats_out = 0;
    endtask

    task automatic issue(input logic [3:0] pic);
        req_valid  = 1'b1;
        req_pic_no = pic;
        expect_start(pic);
        tick();
        req_valid = 1'b0;
        check("busy_after_req", busy, 1'b1);
        check("arvalid_after_req", axi.arvalid_m_inf, 1'b1);
        check("araddr", axi.araddr_m_inf, exp_addr);
        check("ar_const", {axi.arid_m_inf, axi.arlen_m_inf, axi.arsize_m_inf, axi.arburst_m_inf},
              {4'h0, 8'd255, 3'b100, 2'b01});
    endtask

    task automatic wait_done();
        logic got;
        got = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            tick();
            if (done) begin
                got = 1'b1;
                break;
            end
        end
        check("done_seen", got, 1'b1);
        check("done_timing", cyc, last_pop_cyc + 1);
        check("busy_at_done", busy, 1'b0);
        check("beats_out", beats_out, 256);
        $display("burst addr=%h beats=%0d err=%0b", exp_addr, beats_out, err);
    endtask

    task automatic wait_beats(input int n);
        for (int i = 0; i < 2000 && tx_exp < n; i++) tick();
        check("reach_beat", tx_exp >= n, 1'b1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_done"}, done, 1'b0);
        check({tag, "_err"}, err, 1'b0);
        check({tag, "_out_valid"}, out_valid, 1'b0);
        check({tag, "_out_data"}, out_data, '0);
        check({tag, "_out_last"}, out_last, 1'b0);
        check({tag, "_arvalid"}, axi.arvalid_m_inf, 1'b0);
        check({tag, "_araddr"}, axi.araddr_m_inf, '0);
        check({tag, "_rready"}, axi.rready_m_inf, 1'b0);
    endtask

    initial begin
        int hs_before;
        axi.arready_m_inf = 1'b0; axi.rvalid_m_inf = 1'b0; axi.rlast_m_inf = 1'b0;
        axi.rdata_m_inf = '0; axi.rid_m_inf = '0; axi.rresp_m_inf = 2'b00;
        repeat (3) tick();
        check_reset_outputs("reset");
        rst_n = 1'b1;
        tick();

        // pic 3, arready one cycle late, continuous data and sink
        ar_delay = 1; ready_mode = 0;
        issue(4'd3);
        check("araddr_pic3", axi.araddr_m_inf, 32'h0004_3000);
        wait_done();
        check("throughput", last_pop_cyc - first_push_cyc, 256);

        // pic 15 with a toggling sink
        ar_delay = 0; ready_mode = 1; rready_low_cnt = 0;
        issue(4'd15);
        check("araddr_pic15", axi.araddr_m_inf, 32'h0004_F000);
        wait_done();
        check("rready_backpressure", rready_low_cnt > 0, 1'b1);

        // arready held off for 20 cycles
        ar_delay = 20; ready_mode = 0; ar_unstable = 0; rready_early = 0;
        issue(4'd1);
        repeat (10) tick();
        check("ar_wait_arvalid", axi.arvalid_m_inf, 1'b1);
        check("ar_wait_araddr", axi.araddr_m_inf, 32'h0004_1000);
        check("ar_wait_rready", axi.rready_m_inf, 1'b0);
        wait_done();
        check("ar_stable", ar_unstable, 0);
        check("rready_early", rready_early, 0);

        // second request during DATA is ignored; held request accepted on the done cycle
        ar_delay = 0;
        hs_before = ar_hs_cnt;
        issue(4'd0);
        wait_beats(50);
        req_valid = 1'b1; req_pic_no = 4'd7;
        tick();
        req_valid = 1'b0;
        check("ignored_araddr", axi.araddr_m_inf, 32'h0004_0000);
        check("ignored_busy", busy, 1'b1);
        repeat (30) tick();
        req_valid = 1'b1; req_pic_no = 4'd7;
        wait_done();
        check("one_burst_only", ar_hs_cnt - hs_before, 1);
        expect_start(4'd7);
        tick();
        req_valid = 1'b0;
        check("second_busy", busy, 1'b1);
        check("second_araddr", axi.araddr_m_inf, 32'h0004_7000);
        wait_done();

        // asynchronous reset in the middle of a burst
        issue(4'd2);
        wait_beats(100);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("midrst");
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        issue(4'd5);
        wait_done();

        // misplaced rlast on beat 200
        bad_beat = 200;
        issue(4'd9);
        wait_done();
        check("err_after_bad_last", err, LAST_CHK);
        tick();
        check("err_held", err, LAST_CHK);
        bad_beat = -1;
        issue(4'd4);
        check("err_cleared", err, 1'b0);
        wait_done();
        check("err_clean_burst", err, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
